// File: rtl/voice_mac.sv
// Multi-channel gain/mix MAC: one frame sums CHANNELS signed sample*gain products through a
// single registered multiplier, then shifts and saturates the total into oOut.
module voice_mac #(
    parameter int CHANNELS = 3,
    parameter int SW       = 12,
    parameter int GW       = 8,
    parameter int OW       = 16,
    parameter int SHIFT    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CHANNELS*SW-1:0] iSamples,
    input  logic [CHANNELS*GW-1:0] iGains,
    input  logic [CHANNELS-1:0]    iMask,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   oValid,
    output logic [OW-1:0]          oOut
);

    localparam int PW = SW + GW + 1;
    localparam int AW = PW + $clog2(CHANNELS) + 1;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // Extended width so the clamp compares never lose the sign of the shifted sum.
    localparam int EW = ((AW > OW) ? AW : OW) + 1;

    localparam logic signed [EW-1:0] OMAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] OMIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CHANNELS*SW-1:0] samples_q;
    logic [CHANNELS*GW-1:0] gains_q;
    logic [CHANNELS-1:0]    mask_q;
    logic [IW-1:0]          idx_q;
    logic                   last_idx;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic                   prod_vld_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   shifted;
    logic signed [EW-1:0]   shifted_ext;
    logic signed [EW-1:0]   clamped;
    logic [OW-1:0]          out_q;
    logic                   valid_q;

    logic signed [SW-1:0]   cur_s;
    logic [GW-1:0]          cur_g;
    logic                   cur_m;

    assign last_idx = (idx_q == IW'(CHANNELS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart) state_d = RUN;
            RUN:     if (last_idx) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_s = '0;
        cur_g = '0;
        cur_m = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_s = samples_q[k*SW +: SW];
                cur_g = gains_q[k*GW +: GW];
                cur_m = mask_q[k];
            end
        end
    end

    // Gain is unsigned, so it enters the signed multiply with a zero MSB.
    always_comb begin
        prod_d = '0;
        if (!cur_m) begin
            prod_d = PW'(cur_s) * PW'($signed({1'b0, cur_g}));
        end
    end

    always_comb begin
        shifted     = acc_q >>> SHIFT;
        shifted_ext = EW'(shifted);
        clamped     = shifted_ext;
        if (shifted_ext > OMAX) begin
            clamped = OMAX;
        end else if (shifted_ext < OMIN) begin
            clamped = OMIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            samples_q  <= '0;
            gains_q    <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= 1'b0;
            prod_vld_q <= 1'b0;
            if (prod_vld_q) begin
                acc_q <= acc_q + AW'(prod_q);
            end
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        samples_q <= iSamples;
                        gains_q   <= iGains;
                        mask_q    <= iMask;
                        acc_q     <= '0;
                        idx_q     <= '0;
                    end
                end
                RUN: begin
                    prod_q     <= prod_d;
                    prod_vld_q <= 1'b1;
                    idx_q      <= last_idx ? '0 : idx_q + IW'(1);
                end
                DONE: begin
                    out_q   <= OW'(clamped);
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oBusy  = (state_q != IDLE);
    assign oValid = valid_q;
    assign oOut   = out_q;

endmodule

// File: tb/tb_voice_mac.sv
// Self-checking bench for voice_mac: two instances (SHIFT=8 and SHIFT=0) share all stimulus.
module tb_voice_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] samples = '0;
    logic [23:0] gains = '0;
    logic [2:0]  mask = '0;
    logic        start = 1'b0;

    logic        busy8, valid8, busy0, valid0;
    logic [15:0] out8, out0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    voice_mac #(.CHANNELS(3), .SW(12), .GW(8), .OW(16), .SHIFT(8)) dut8 (
        .clk(clk), .rst(rst), .iSamples(samples), .iGains(gains), .iMask(mask),
        .iStart(start), .oBusy(busy8), .oValid(valid8), .oOut(out8)
    );

    voice_mac #(.CHANNELS(3), .SW(12), .GW(8), .OW(16), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .iSamples(samples), .iGains(gains), .iMask(mask),
        .iStart(start), .oBusy(busy0), .oValid(valid0), .oOut(out0)
    );

    // Reference: plain sum of products, floor shift, clamp.
    function automatic logic [15:0] model(input logic [35:0] s, input logic [23:0] g,
                                          input logic [2:0] m, input int sh);
        longint acc = 0;
        longint sv, gv;
        logic [11:0] sb;
        logic [7:0]  gb;
        for (int k = 0; k < 3; k++) begin
            sb = s[k*12 +: 12];
            gb = g[k*8 +: 8];
            sv = longint'($signed(sb));
            gv = longint'(gb);
            if (!m[k]) acc += sv * gv;
        end
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse iStart so it is sampled at the next edge (T); returns just after T.
    task automatic start_frame(input logic [35:0] s, input logic [23:0] g, input logic [2:0] m);
        samples = s;
        gains   = g;
        mask    = m;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Counts edges after T until oValid; 0 means the bound expired.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (valid8) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || out8 !== 16'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b valid=%b out=%0d, want 0 0 0", busy8, valid8, out8);
        end
        checks++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0 || out0 !== 16'd0) begin
            errors++;
            $display("FAIL reset0: busy=%b valid=%b out=%0d, want 0 0 0", busy0, valid0, out0);
        end
        // rst must win over a coincident iStart.
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates_start: busy=%b want 0", busy8);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_scale();
        logic [35:0] s = {3{12'sd2047}};
        logic [23:0] g = {3{8'd255}};
        int bad_busy = 0;
        int bad_valid = 0;
        start_frame(s, g, 3'b000);
        for (int i = 0; i < 5; i++) begin
            if (busy8 !== 1'b1) bad_busy++;
            if (valid8 !== 1'b0) bad_valid++;
            step();
        end
        checks++;
        if (bad_busy != 0 || bad_valid != 0) begin
            errors++;
            $display("FAIL timing_during_frame: busy_low=%0d valid_early=%0d want 0 0",
                     bad_busy, bad_valid);
        end
        checks++;
        if (valid8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL valid_at_T5: valid=%b busy=%b want 1 0", valid8, busy8);
        end
        checks++;
        if (out8 !== 16'sd6117) begin
            errors++;
            $display("FAIL full_scale_shift8: got %0d want 6117", $signed(out8));
        end
        checks++;
        if (out0 !== 16'sd32767) begin
            errors++;
            $display("FAIL sat_pos_shift0: got %0d want 32767", $signed(out0));
        end
        step();
        checks++;
        if (valid8 !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: valid=%b want 0", valid8);
        end
    endtask

    task automatic test_saturate_neg();
        int cyc;
        start_frame({3{12'h800}}, {3{8'd255}}, 3'b000);
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out0 !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg_shift0: cyc=%0d out=%0d want 5 -32768", cyc, $signed(out0));
        end
        step();
    endtask

    task automatic test_floor();
        int cyc;
        start_frame({12'd0, 12'd0, 12'hfff}, {8'd0, 8'd0, 8'd1}, 3'b000);
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out8 !== 16'hffff) begin
            errors++;
            $display("FAIL floor_neg: cyc=%0d out=%0d want 5 -1", cyc, $signed(out8));
        end
        step();
        start_frame({12'd0, 12'd0, 12'd255}, {8'd0, 8'd0, 8'd1}, 3'b000);
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out8 !== 16'd0) begin
            errors++;
            $display("FAIL floor_pos: cyc=%0d out=%0d want 5 0", cyc, $signed(out8));
        end
        step();
    endtask

    task automatic test_mask_and_ignore();
        int cyc;
        int extra = 0;
        start_frame({3{12'd1000}}, {3{8'd128}}, 3'b010);
        // Changed inputs sampled at T+1, extra iStart sampled at T+2: both must be ignored.
        samples = {3{12'd5}};
        gains   = {3{8'd7}};
        mask    = 3'b000;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 2;
        for (int i = 3; i <= 20; i++) begin
            step();
            if (valid8) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc != 5 || out8 !== 16'd1000) begin
            errors++;
            $display("FAIL mask_snapshot: cyc=%0d out=%0d want 5 1000", cyc, $signed(out8));
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid8 || busy8) extra++;
        end
        checks++;
        if (extra != 0 || out8 !== 16'd1000) begin
            errors++;
            $display("FAIL start_ignored_hold: extra=%0d out=%0d want 0 1000",
                     extra, $signed(out8));
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int stray = 0;
        logic [15:0] exp8;
        start_frame({3{12'd2047}}, {3{8'd255}}, 3'b000);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || out8 !== 16'd0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b valid=%b out=%0d want 0 0 0",
                     busy8, valid8, $signed(out8));
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid8 || busy8) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abandoned_frame: stray=%0d want 0", stray);
        end
        exp8 = model({12'd300, 12'hf00, 12'd77}, {8'd9, 8'd200, 8'd33}, 3'b000, 8);
        start_frame({12'd300, 12'hf00, 12'd77}, {8'd9, 8'd200, 8'd33}, 3'b000);
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out8 !== exp8) begin
            errors++;
            $display("FAIL after_reset_frame: cyc=%0d out=%0d want 5 %0d",
                     cyc, $signed(out8), $signed(exp8));
        end
    endtask

    // Random frames started the cycle after each oValid.
    task automatic test_back_to_back();
        int cyc;
        int bad = 0;
        logic [35:0] s;
        logic [23:0] g;
        logic [2:0]  m;
        logic [15:0] e8, e0;
        for (int n = 0; n < 40; n++) begin
            s = {$urandom(), $urandom()};
            g = 24'($urandom());
            m = 3'($urandom_range(0, 7));
            if (n % 4 == 0) m = 3'b000;
            e8 = model(s, g, m, 8);
            e0 = model(s, g, m, 0);
            start_frame(s, g, m);
            samples = {$urandom(), $urandom()};
            wait_valid(cyc);
            checks++;
            if (cyc != 5 || out8 !== e8 || out0 !== e0) begin
                errors++;
                bad++;
                if (bad < 6)
                    $display("FAIL random_frame %0d: cyc=%0d out8=%0d out0=%0d want 5 %0d %0d",
                             n, cyc, $signed(out8), $signed(out0), $signed(e8), $signed(e0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_saturate_neg();
        test_floor();
        test_mask_and_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voice_mac.md
VOICE_MAC -- requirements
Module: voice_mac

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of channels summed per frame (>=1).
REQ-002 SHALL have parameter SW, default 12: signed sample width per channel.
REQ-003 SHALL have parameter GW, default 8: unsigned gain width per channel.
REQ-004 SHALL have parameter OW, default 16: signed output width.
REQ-005 SHALL have parameter SHIFT, default 8: arithmetic right shift applied to the accumulated sum before saturation.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port iSamples, input, CHANNELS*SW: signed samples; channel k at bits [k*SW +: SW].
REQ-009 SHALL have port iGains, input, CHANNELS*GW: unsigned gains; channel k at bits [k*GW +: GW].
REQ-010 SHALL have port iMask, input, CHANNELS: bit k=1 mutes channel k (contributes 0).
REQ-011 SHALL have port iStart, input, 1: single-cycle frame request.
REQ-012 SHALL have port oBusy, output, 1: high while a frame is in progress.
REQ-013 SHALL have port oValid, output, 1: one-cycle pulse, oOut updated this cycle.
REQ-014 SHALL have port oOut, output, OW: signed saturated frame result; holds value until the next oValid.

Function
REQ-015 SHALL use one shared registered multiplier: signed SW sample times GW gain zero-extended to GW+1 signed, 1-cycle latency, exact product width SW+GW+1.
REQ-016 SHALL run FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: oBusy=0; iStart=1 sampled at edge T snapshots iSamples, iGains and iMask into registers, clears accumulator, sets index 0, enters RUN.
REQ-018 RUN: issues channel index to multiplier each cycle for CHANNELS cycles (edges T+1..T+CHANNELS); muted channel issues product 0; after last index enters DRAIN.
REQ-019 Accumulator SHALL add each registered product one cycle after issue; width SW+GW+1+clog2(CHANNELS)+1, never overflows.
REQ-020 DRAIN: adds final product (edge T+CHANNELS+1), enters DONE.
REQ-021 DONE: at edge T+CHANNELS+2 oOut <= saturate(acc >>> SHIFT) to [-2^(OW-1), 2^(OW-1)-1]; oValid=1 for that one cycle; return to IDLE.
REQ-022 Shift SHALL be arithmetic (floor toward minus infinity, no rounding).
REQ-023 oBusy SHALL be 1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-024 iStart while oBusy=1 SHALL be ignored (no queueing, no restart); iStart in the same cycle DONE returns to IDLE is also ignored.
REQ-025 Input changes after the snapshot edge SHALL NOT affect the current frame.
REQ-026 Back-to-back frames: iStart may be accepted the cycle after oValid; throughput one frame per CHANNELS+3 cycles.
REQ-027 CHANNELS=1 SHALL work: RUN lasts one cycle.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, oBusy=0, oValid=0, oOut=0, accumulator=0, index=0, regardless of state; rst dominates iStart in the same cycle.
REQ-029 Frame interrupted by rst SHALL be abandoned; no oValid for it after reset release.

Verification (CHANNELS=3, SW=12, GW=8, OW=16 unless stated)
REQ-030 SHIFT=8, samples 2047,2047,2047, gains 255, mask 0, iStart at T -> oValid only at T+5, oOut=6117, oBusy high T+1..T+5 edges.
REQ-031 SHIFT=0, same inputs -> oOut=32767 (saturated); samples -2048 x3, gains 255 -> oOut=-32768.
REQ-032 SHIFT=8, sample0=-1 gain0=1, others 0 -> oOut=-1 (floor); sample0=255 gain0=1 -> oOut=0.
REQ-033 SHIFT=8, samples 1000,1000,1000, gains 128, mask 3'b010 -> oOut=1000; iStart pulsed at T+2 ignored, inputs changed at T+1 ignored.
REQ-034 Start frame, assert rst at T+3 one cycle -> oBusy=0, oOut=0, no oValid; new iStart after release completes normally at start+5.
